shift_register_unit: RTL

Holds the two operand registers A and B of the logic processor and shifts them serially, LSB first, for one full operation. It drives the serial bit pair (LSBs of A and B) into the compute and routing path. It takes the routed bit pair back in at the MSB end, so after WIDTH shifts each register holds its new value. It contains the operation control FSM (idle, shift, hold) and the shift counter.

---
 rtl/shift_register_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/shift_register_unit.sv
// shift_register_unit
// Operand registers A and B of the bit-serial logic processor plus the
// operation control FSM (idle -> shift -> hold) and shift counter.
// Each operation shifts both registers right WIDTH times, LSB first. The
// routed result bits come back in at the MSB end, so after WIDTH shifts A and
// B hold their new values.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   execute      level request for one operation; must drop before the next run
//   load_a       parallel-load A from din (IDLE only)
//   load_b       parallel-load B from din (IDLE only)
//   din          parallel load data
//   a_serial_in  routed bit shifted into A's MSB
//   b_serial_in  routed bit shifted into B's MSB
//   a_serial_out A[0]
//   b_serial_out B[0]
//   a_value      current A contents
//   b_value      current B contents
//   shift_active high in SHIFT
//   done         high in HOLD
module shift_register_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             execute,
    input  logic             load_a,
    input  logic             load_b,
    input  logic [WIDTH-1:0] din,
    input  logic             a_serial_in,
    input  logic             b_serial_in,
    output logic             a_serial_out,
    output logic             b_serial_out,
    output logic [WIDTH-1:0] a_value,
    output logic [WIDTH-1:0] b_value,
    output logic             shift_active,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] a_nxt;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] b_nxt;

    // State, counter and operand registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            a_reg <= a_nxt;
            b_reg <= b_nxt;
        end
    end

    // Next-state, counter and register update logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        a_nxt     = a_reg;
        b_nxt     = b_reg;
        case (state)
            ST_IDLE: begin
                // execute wins over loads; the start edge itself does not shift
                if (execute) begin
                    state_nxt = ST_SHIFT;
                    cnt_nxt   = '0;
                end else begin
                    if (load_a) a_nxt = din;
                    if (load_b) b_nxt = din;
                end
            end
            ST_SHIFT: begin
                a_nxt = {a_serial_in, a_reg[WIDTH-1:1]};
                b_nxt = {b_serial_in, b_reg[WIDTH-1:1]};
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                // a still-high execute must not retrigger a run
                if (!execute) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign a_serial_out = a_reg[0];
    assign b_serial_out = b_reg[0];
    assign a_value      = a_reg;
    assign b_value      = b_reg;
    assign shift_active = (state == ST_SHIFT);
    assign done         = (state == ST_HOLD);

endmodule
